// File: rtl/wash_seq_if.sv
`default_nettype none
// ============================================================================
// Module    : wash_seq_if
// Purpose   : Signal bundle between the pre-wash setup stage (master) and the
//             wash cycle sequencer (slave). The abort strobe exists only when
//             WASH_ABORT_EN is defined.
// Revision  : 1.0 - initial release
// ============================================================================
interface wash_seq_if;
  // setup stage -> sequencer
  logic       start;
  logic [1:0] mode;
  logic [4:0] weight;
  logic [9:0] bal_in;
  logic       pause;
  logic       lid_open;
`ifdef WASH_ABORT_EN
  logic       abort;
`endif
  // sequencer -> setup stage / display
  logic       busy;
  logic [2:0] phase;
  logic [9:0] remain;
  logic [9:0] bal_out;
  logic       bal_we;
  logic       alarm;
  logic       err;

  modport master (
`ifdef WASH_ABORT_EN
    output abort,
`endif
    output start, mode, weight, bal_in, pause, lid_open,
    input  busy, phase, remain, bal_out, bal_we, alarm, err
  );

  modport slave (
`ifdef WASH_ABORT_EN
    input  abort,
`endif
    input  start, mode, weight, bal_in, pause, lid_open,
    output busy, phase, remain, bal_out, bal_we, alarm, err
  );
endinterface
`default_nettype wire

// File: rtl/wash_seq.sv
`default_nettype none
// ============================================================================
// Module    : wash_seq
// Purpose   : Wash cycle sequencer. Charges the cycle price against the
//             balance, then runs WASH/RINSE/SPIN with a per-second countdown,
//             handles pause / lid interlock, and holds a done or error
//             indication for a fixed number of seconds.
//             Optional macro WASH_ABORT_EN: abort from PAUSED with half refund.
// Revision  : 1.0 - initial release
// ============================================================================
module wash_seq #(
  parameter int TICK_DIV = 100000000,
  parameter int DONE_SEC = 5,
  parameter int ERR_SEC  = 3
) (
  input  logic      clk,
  input  logic      rst,
  wash_seq_if.slave bus
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] c_presc_max = PRESC_W'(TICK_DIV - 1);
  localparam logic [9:0]         c_done_time = 10'(DONE_SEC);
  localparam logic [9:0]         c_err_time  = 10'(ERR_SEC);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_WASH   = 3'd2,
    S_RINSE  = 3'd3,
    S_SPIN   = 3'd4,
    S_PAUSED = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t               r_state, w_state_nxt;
  state_t               r_saved, w_saved_nxt;
  logic [9:0]           r_remain, w_remain_nxt;
  logic [PRESC_W-1:0]   r_presc, w_presc_nxt;
  logic [1:0]           r_mode, w_mode_nxt;
  logic [4:0]           r_wt, w_wt_nxt;
  logic [9:0]           r_price, w_price_nxt;
  logic [9:0]           r_bal_out, w_bal_out_nxt;
  logic                 r_bal_we, w_bal_we_nxt;

  logic [4:0]           w_wt_clamp;
  logic [1:0]           w_rate;
  logic [9:0]           w_price_new;
  logic [9:0]           w_base_wash, w_t_wash, w_t_rinse, w_t_spin;
  state_t               w_after_state;
  logic [9:0]           w_after_time;
  logic                 w_tick;
  logic [2:0]           w_phase;
`ifdef WASH_ABORT_EN
  logic [10:0]          w_refund_sum;
`endif

  assign w_tick     = (r_presc == c_presc_max);
  assign w_wt_clamp = (bus.weight > 5'd20) ? 5'd20 : bus.weight;

  // Price rate per mode, evaluated on the live inputs so it can be latched on start
  always_comb begin
    w_rate = 2'd1;
    case (bus.mode)
      2'd0:    w_rate = 2'd2;
      2'd1:    w_rate = 2'd1;
      2'd2:    w_rate = 2'd3;
      default: w_rate = 2'd1;
    endcase
  end

  assign w_price_new = 10'(w_rate) * 10'(w_wt_clamp);

  // Phase durations for the latched mode; wash time grows with the load
  always_comb begin
    w_base_wash = 10'd0;
    w_t_rinse   = 10'd0;
    w_t_spin    = 10'd0;
    case (r_mode)
      2'd0: begin w_base_wash = 10'd10; w_t_rinse = 10'd6; w_t_spin = 10'd4; end
      2'd1: begin w_base_wash = 10'd5;  w_t_rinse = 10'd3; w_t_spin = 10'd2; end
      2'd2: begin w_base_wash = 10'd15; w_t_rinse = 10'd9; w_t_spin = 10'd6; end
      default: begin w_base_wash = 10'd0; w_t_rinse = 10'd0; w_t_spin = 10'd4; end
    endcase
    w_t_wash = (w_base_wash == 10'd0) ? 10'd0 : (w_base_wash + 10'(r_wt));
  end

  // Next non-zero phase after the current one; CHECK starts the chain at WASH so
  // zero-length phases are skipped without spending a tick
  always_comb begin
    w_after_state = S_DONE;
    w_after_time  = c_done_time;
    if ((r_state == S_CHECK) && (w_t_wash != 10'd0)) begin
      w_after_state = S_WASH;
      w_after_time  = w_t_wash;
    end else if (((r_state == S_CHECK) || (r_state == S_WASH)) && (w_t_rinse != 10'd0)) begin
      w_after_state = S_RINSE;
      w_after_time  = w_t_rinse;
    end else if (((r_state == S_CHECK) || (r_state == S_WASH) || (r_state == S_RINSE))
                 && (w_t_spin != 10'd0)) begin
      w_after_state = S_SPIN;
      w_after_time  = w_t_spin;
    end
  end

`ifdef WASH_ABORT_EN
  assign w_refund_sum = {1'b0, bus.bal_in} + {2'b00, r_price[9:1]};
`endif

  // Next-state and datapath update for the sequencer
  always_comb begin
    w_state_nxt   = r_state;
    w_saved_nxt   = r_saved;
    w_remain_nxt  = r_remain;
    w_presc_nxt   = r_presc;
    w_mode_nxt    = r_mode;
    w_wt_nxt      = r_wt;
    w_price_nxt   = r_price;
    w_bal_out_nxt = r_bal_out;
    w_bal_we_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_remain_nxt = 10'd0;
        w_presc_nxt  = '0;
        if (bus.start) begin
          w_mode_nxt  = bus.mode;
          w_wt_nxt    = w_wt_clamp;
          w_price_nxt = w_price_new;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        w_presc_nxt = '0;
        if (bus.bal_in >= r_price) begin
          w_bal_out_nxt = bus.bal_in - r_price;
          w_bal_we_nxt  = 1'b1;
          w_state_nxt   = w_after_state;
          w_remain_nxt  = w_after_time;
        end else begin
          w_state_nxt  = S_ERR;
          w_remain_nxt = c_err_time;
        end
      end
      S_WASH, S_RINSE, S_SPIN: begin
        // pause has priority over a coincident tick; everything is frozen
        if (bus.pause || bus.lid_open) begin
          w_saved_nxt = r_state;
          w_state_nxt = S_PAUSED;
        end else if (w_tick) begin
          w_presc_nxt = '0;
          if (r_remain == 10'd1) begin
            w_state_nxt  = w_after_state;
            w_remain_nxt = w_after_time;
          end else begin
            w_remain_nxt = r_remain - 10'd1;
          end
        end else begin
          w_presc_nxt = r_presc + 1'b1;
        end
      end
      S_PAUSED: begin
`ifdef WASH_ABORT_EN
        if (bus.abort) begin
          w_state_nxt   = S_IDLE;
          w_remain_nxt  = 10'd0;
          w_presc_nxt   = '0;
          w_bal_out_nxt = (w_refund_sum > 11'd999) ? 10'd999 : w_refund_sum[9:0];
          w_bal_we_nxt  = 1'b1;
        end else if (bus.pause && !bus.lid_open) begin
          w_state_nxt = r_saved;
        end
`else
        if (bus.pause && !bus.lid_open) begin
          w_state_nxt = r_saved;
        end
`endif
      end
      S_DONE, S_ERR: begin
        if (w_tick) begin
          w_presc_nxt = '0;
          if (r_remain == 10'd1) begin
            w_state_nxt  = S_IDLE;
            w_remain_nxt = 10'd0;
          end else begin
            w_remain_nxt = r_remain - 10'd1;
          end
        end else begin
          w_presc_nxt = r_presc + 1'b1;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_remain_nxt = 10'd0;
        w_presc_nxt  = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_saved <= S_WASH;
    end else begin
      r_state <= w_state_nxt;
      r_saved <= w_saved_nxt;
    end
  end

  // Datapath registers: countdown, prescaler, latched job and balance result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_remain  <= 10'd0;
      r_presc   <= '0;
      r_mode    <= 2'd0;
      r_wt      <= 5'd0;
      r_price   <= 10'd0;
      r_bal_out <= 10'd0;
      r_bal_we  <= 1'b0;
    end else begin
      r_remain  <= w_remain_nxt;
      r_presc   <= w_presc_nxt;
      r_mode    <= w_mode_nxt;
      r_wt      <= w_wt_nxt;
      r_price   <= w_price_nxt;
      r_bal_out <= w_bal_out_nxt;
      r_bal_we  <= w_bal_we_nxt;
    end
  end

  // Display phase code; CHECK shows as idle while busy is already high
  always_comb begin
    w_phase = 3'd0;
    case (r_state)
      S_WASH:   w_phase = 3'd1;
      S_RINSE:  w_phase = 3'd2;
      S_SPIN:   w_phase = 3'd3;
      S_PAUSED: w_phase = 3'd4;
      S_DONE:   w_phase = 3'd5;
      S_ERR:    w_phase = 3'd6;
      default:  w_phase = 3'd0;
    endcase
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.phase   = w_phase;
  assign bus.remain  = r_remain;
  assign bus.bal_out = r_bal_out;
  assign bus.bal_we  = r_bal_we;
  assign bus.alarm   = (r_state == S_DONE);
  assign bus.err     = (r_state == S_ERR);

endmodule
`default_nettype wire
